// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_sequencer: iterative RV32M multiply/divide unit for the EX stage. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module muldiv_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            startE,
   input  logic [2:0]      func3E,
   input  logic [XLEN-1:0] srcAE,
   input  logic [XLEN-1:0] srcBE,
   input  logic            abortE,
   output logic            stallMD,
   output logic            busyMD,
   output logic            doneMD,
   output logic [XLEN-1:0] resultMD
);

   localparam int                  c_cnt_w    = $clog2(XLEN);
   localparam logic [c_cnt_w-1:0]  c_cnt_init = c_cnt_w'(XLEN - 1);
   localparam logic [XLEN-1:0]     c_ones     = {XLEN{1'b1}};
   localparam logic [XLEN-1:0]     c_int_min  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             r_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [2:0]         r_func;
   logic [XLEN-1:0]    r_a;
   logic [XLEN-1:0]    r_b;
   logic [XLEN-1:0]    r_hi;
   logic [XLEN-1:0]    r_lo;
   logic               r_neg_a;
   logic               r_neg_b;
   logic               r_done;
   logic               r_busy;
   logic [XLEN-1:0]    r_result;

   logic               w_a_signed;
   logic               w_b_signed;
   logic               w_neg_a;
   logic               w_neg_b;
   logic [XLEN-1:0]    w_mag_a;
   logic [XLEN-1:0]    w_mag_b;
   logic               w_is_div;
   logic               w_div_zero;
   logic               w_div_ovf;
   logic [XLEN-1:0]    w_special_res;
   logic               w_accept;

   always_comb begin
      w_a_signed = 1'b0;
      w_b_signed = 1'b0;
      case (func3E)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            w_a_signed = 1'b1;
            w_b_signed = 1'b1;
         end
         3'b010:  w_a_signed = 1'b1;
         default: ;
      endcase
   end

   assign w_neg_a    = w_a_signed & srcAE[XLEN-1];
   assign w_neg_b    = w_b_signed & srcBE[XLEN-1];
   assign w_mag_a    = w_neg_a ? (~srcAE + 1'b1) : srcAE;
   assign w_mag_b    = w_neg_b ? (~srcBE + 1'b1) : srcBE;
   assign w_is_div   = func3E[2];
   assign w_div_zero = w_is_div & (srcBE == '0);
   assign w_div_ovf  = w_is_div & ~func3E[0] & (srcAE == c_int_min) & (srcBE == c_ones);
   assign w_accept   = (r_state == S_IDLE) & startE & ~abortE;

   // func3E[1] separates REM* from DIV* among the divide encodings
   always_comb begin
      w_special_res = '0;
      if (w_div_zero)
         w_special_res = func3E[1] ? srcAE : c_ones;
      else
         w_special_res = func3E[1] ? '0 : c_int_min;
   end

   // Multiply step: conditional add of the multiplicand, then shift {sum,lo} right
   logic [XLEN:0]      w_msum;
   assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});

   // Divide step: shift {rem,quot} left, keep the difference only if it is non-negative
   logic [XLEN:0]      w_dshift;
   logic               w_dge;
   logic [XLEN-1:0]    w_ddiff;
   assign w_dshift = {r_hi, r_lo[XLEN-1]};
   assign w_dge    = w_dshift >= {1'b0, r_b};
   assign w_ddiff  = w_dshift[XLEN-1:0] - r_b;

   logic [2*XLEN-1:0]  w_prod;
   logic [2*XLEN-1:0]  w_prod_fix;
   logic [XLEN-1:0]    w_quot_fix;
   logic [XLEN-1:0]    w_rem_fix;
   logic [XLEN-1:0]    w_fix_res;

   assign w_prod     = {r_hi, r_lo};
   assign w_prod_fix = (r_neg_a ^ r_neg_b) ? (~w_prod + 1'b1) : w_prod;
   assign w_quot_fix = (r_neg_a ^ r_neg_b) ? (~r_lo + 1'b1) : r_lo;
   assign w_rem_fix  = r_neg_a ? (~r_hi + 1'b1) : r_hi;

   always_comb begin
      w_fix_res = '0;
      case (r_func)
         3'b000:                 w_fix_res = w_prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         w_fix_res = w_quot_fix;
         default:                w_fix_res = w_rem_fix;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_func   <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_neg_a  <= 1'b0;
         r_neg_b  <= 1'b0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
         r_result <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_func  <= func3E;
                  r_neg_a <= w_neg_a;
                  r_neg_b <= w_neg_b;
                  r_a     <= w_mag_a;
                  r_b     <= w_mag_b;
                  r_hi    <= '0;
                  r_lo    <= w_is_div ? w_mag_a : w_mag_b;
                  r_busy  <= 1'b1;
                  if (w_div_zero || w_div_ovf) begin
                     r_result <= w_special_res;
                     r_done   <= 1'b1;
                     r_state  <= S_DONE;
                  end else begin
                     r_cnt   <= c_cnt_init;
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (abortE) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  if (r_func[2]) begin
                     r_hi <= w_dge ? w_ddiff : w_dshift[XLEN-1:0];
                     r_lo <= {r_lo[XLEN-2:0], w_dge};
                  end else begin
                     r_hi <= w_msum[XLEN:1];
                     r_lo <= {w_msum[0], r_lo[XLEN-1:1]};
                  end
                  r_cnt <= r_cnt - 1'b1;
                  if (r_cnt == '0)
                     r_state <= S_FIX;
               end
            end
            S_FIX: begin
               if (abortE) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_result <= w_fix_res;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign stallMD  = w_accept | (r_state == S_RUN) | (r_state == S_FIX);
   assign busyMD   = r_busy;
   assign doneMD   = r_done;
   assign resultMD = r_result;

endmodule
`default_nettype wire
